// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// Op encoding matches RV32M funct3[1:0]; op[1] selects remainder, op[0] selects unsigned.
package div_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift rem:quo left, trial-subtract divisor, restore on borrow.
// Purely combinational; the caller registers rem_o/quo_o.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted_rem;
    logic [XLEN:0] trial;
    logic          borrow;

    // rem < divisor on entry, so the 33-bit difference never wraps past its sign bit.
    always_comb begin
        shifted_rem = {rem_i, quo_i[XLEN-1]};
        trial       = shifted_rem - {1'b0, divisor_i};
        borrow      = trial[XLEN];
        rem_o       = borrow ? shifted_rem[XLEN-1:0] : trial[XLEN-1:0];
        quo_o       = {quo_i[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 32-bit RV32M divider: 32-cycle restoring core, sign fix-up, 1-cycle divide-by-zero path.
// Result valid one cycle after the last step; start is ignored while busy (no queuing).
module seq_divider
    import div_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e        state_q, state_d;
    div_op_e           op_q, op_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;
    div_op_e           in_op;
    logic              in_signed;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign in_op     = div_op_e'(i_op);
    assign in_signed = op_is_signed(in_op);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    op_d   = in_op;
                    busy_d = 1'b1;
                    if (i_divisor == '0) begin
                        // RV32M defines x/0: quotient all-ones, remainder is the raw dividend.
                        result_d = in_op[1] ? i_dividend : '1;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        quo_d     = (in_signed && i_dividend[XLEN-1]) ? -i_dividend : i_dividend;
                        divisor_d = (in_signed && i_divisor[XLEN-1])  ? -i_divisor  : i_divisor;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = in_signed && (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
                        neg_rem_d = in_signed && i_dividend[XLEN-1];
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    // Overflow case (MIN / -1) falls out naturally: |MIN| negated is MIN again.
                    if (op_q[1]) begin
                        result_d = neg_rem_q ? -step_rem : step_rem;
                    end else begin
                        result_d = neg_quo_q ? -step_quo : step_quo;
                    end
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule
